// File: rtl/slow_dac_ramp_if.sv
// Bundle between the setpoint source and the slow-DAC ramp: targets and slew
// controls go in, ramped channel values and sweep status come back.
interface slow_dac_ramp_if #(
    parameter int NCH  = 16,
    parameter int DIVW = 16
);
    logic signed [15:0] target [0:NCH-1];
    logic [14:0]        step;
    logic [DIVW-1:0]    div;
    logic               hold;

    logic signed [15:0] sout0,  sout1,  sout2,  sout3;
    logic signed [15:0] sout4,  sout5,  sout6,  sout7;
    logic signed [15:0] sout8,  sout9,  sout10, sout11;
    logic signed [15:0] sout12, sout13, sout14, sout15;
    logic               busy;
    logic               settled;

    modport master (
        output target, step, div, hold,
        input  sout0, sout1, sout2, sout3, sout4, sout5, sout6, sout7,
        input  sout8, sout9, sout10, sout11, sout12, sout13, sout14, sout15,
        input  busy, settled
    );

    modport slave (
        input  target, step, div, hold,
        output sout0, sout1, sout2, sout3, sout4, sout5, sout6, sout7,
        output sout8, sout9, sout10, sout11, sout12, sout13, sout14, sout15,
        output busy, settled
    );
endinterface

// File: rtl/slow_dac_ramp.sv
// Slew limiter for sixteen slow-DAC setpoints: on every divider tick one sweep
// walks all channels through a single shared step/compare datapath.
module slow_dac_ramp #(
    parameter int NCH  = 16,
    parameter int DIVW = 16
) (
    input  logic           clk,
    input  logic           rst,
    slow_dac_ramp_if.slave bus
);
    localparam int IDXW = $clog2(NCH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDXW-1:0]     r_idx;
    logic [IDXW-1:0]     w_idx_next;
    logic                w_proc;

    logic [DIVW-1:0]     r_cnt;
    logic [DIVW-1:0]     w_pm1;
    logic                w_tick;

    logic signed [15:0]  r_sout [0:NCH-1];
    logic [NCH-1:0]      r_at_target;
    logic                r_settled;

    logic signed [15:0]  w_tgt;
    logic signed [15:0]  w_cur;
    logic signed [16:0]  w_diff;
    logic [16:0]         w_abs;
    logic signed [15:0]  w_new;

    // Period is clamped to at least 16 so a sweep always fits inside one tick.
    assign w_pm1  = (bus.div < DIVW'(15)) ? DIVW'(15) : bus.div;
    assign w_tick = (r_cnt == w_pm1);

    // A shrinking div can leave cnt beyond the new end; it then wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_pm1) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_proc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && !bus.hold) begin
                    w_state_next = S_SWEEP;
                    w_idx_next   = '0;
                end
            end
            S_SWEEP: begin
                w_proc     = 1'b1;
                w_idx_next = r_idx + 1'b1;
                // With the minimum period the next tick coincides with the last channel.
                if (r_idx == IDXW'(NCH - 1)) begin
                    if (w_tick && !bus.hold) begin
                        w_state_next = S_SWEEP;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    assign w_tgt  = bus.target[r_idx];
    assign w_cur  = r_sout[r_idx];
    assign w_diff = $signed({w_tgt[15], w_tgt}) - $signed({w_cur[15], w_cur});
    assign w_abs  = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);

    // The stepped result always lands between cur and target, so 16-bit wrap math is exact.
    always_comb begin
        w_new = w_tgt;
        if ((bus.step != 15'd0) && (w_abs > {2'b00, bus.step})) begin
            if (w_diff[16]) begin
                w_new = w_cur - $signed({1'b0, bus.step});
            end else begin
                w_new = w_cur + $signed({1'b0, bus.step});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_sout[i] <= '0;
            end
            r_at_target <= '0;
            r_settled   <= 1'b0;
        end else begin
            if (w_proc) begin
                r_sout[r_idx]      <= w_new;
                r_at_target[r_idx] <= (w_new == w_tgt);
            end
            r_settled <= &r_at_target;
        end
    end

    assign bus.busy    = (r_state == S_SWEEP);
    assign bus.settled = r_settled;

    assign bus.sout0  = r_sout[0];
    assign bus.sout1  = r_sout[1];
    assign bus.sout2  = r_sout[2];
    assign bus.sout3  = r_sout[3];
    assign bus.sout4  = r_sout[4];
    assign bus.sout5  = r_sout[5];
    assign bus.sout6  = r_sout[6];
    assign bus.sout7  = r_sout[7];
    assign bus.sout8  = r_sout[8];
    assign bus.sout9  = r_sout[9];
    assign bus.sout10 = r_sout[10];
    assign bus.sout11 = r_sout[11];
    assign bus.sout12 = r_sout[12];
    assign bus.sout13 = r_sout[13];
    assign bus.sout14 = r_sout[14];
    assign bus.sout15 = r_sout[15];
endmodule

// File: tb/tb_slow_dac_ramp.sv
// Directed bench for slow_dac_ramp: a vector table for ramp sequences plus
// hand-written sequences for divider clamp, hold and mid-sweep reset.
module tb_slow_dac_ramp;
    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    slow_dac_ramp_if bus ();

    slow_dac_ramp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [15:0] obs [0:15];
    assign obs[0]  = bus.sout0;
    assign obs[1]  = bus.sout1;
    assign obs[2]  = bus.sout2;
    assign obs[3]  = bus.sout3;
    assign obs[4]  = bus.sout4;
    assign obs[5]  = bus.sout5;
    assign obs[6]  = bus.sout6;
    assign obs[7]  = bus.sout7;
    assign obs[8]  = bus.sout8;
    assign obs[9]  = bus.sout9;
    assign obs[10] = bus.sout10;
    assign obs[11] = bus.sout11;
    assign obs[12] = bus.sout12;
    assign obs[13] = bus.sout13;
    assign obs[14] = bus.sout14;
    assign obs[15] = bus.sout15;

    typedef struct {
        int   ch;
        int   tgt;
        int   stp;
        int   exp_sout;
        logic exp_settled;
    } vec_t;

    vec_t vecs [13];
    int   tj   [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic val, input int limit, input string tag);
        int n;
        n = 0;
        while (bus.busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== val) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for busy=%0b", tag, val);
        end
    endtask

    // Waits for the next sweep, lets it finish, then allows settled to update.
    task automatic run_sweep(input string tag, output int rise_cyc);
        wait_busy(1'b1, 300, tag);
        rise_cyc = cyc;
        wait_busy(1'b0, 20, tag);
        repeat (2) @(negedge clk);
    endtask

    function automatic int count_nonzero();
        int nz;
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            if (obs[i] != 16'sd0) nz++;
        end
        return nz;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;
        int highs;
        int rise;
        int prev_rise;
        int t1;
        int t2;

        vecs[0]  = '{ch: 3,  tgt: 1000,   stp: 300,   exp_sout: 300,    exp_settled: 1'b0};
        vecs[1]  = '{ch: 3,  tgt: 1000,   stp: 300,   exp_sout: 600,    exp_settled: 1'b0};
        vecs[2]  = '{ch: 3,  tgt: 1000,   stp: 300,   exp_sout: 900,    exp_settled: 1'b0};
        vecs[3]  = '{ch: 3,  tgt: 1000,   stp: 300,   exp_sout: 1000,   exp_settled: 1'b1};
        vecs[4]  = '{ch: 0,  tgt: 500,    stp: 0,     exp_sout: 500,    exp_settled: 1'b1};
        vecs[5]  = '{ch: 0,  tgt: -32768, stp: 10000, exp_sout: -9500,  exp_settled: 1'b0};
        vecs[6]  = '{ch: 0,  tgt: -32768, stp: 10000, exp_sout: -19500, exp_settled: 1'b0};
        vecs[7]  = '{ch: 0,  tgt: -32768, stp: 10000, exp_sout: -29500, exp_settled: 1'b0};
        vecs[8]  = '{ch: 0,  tgt: -32768, stp: 10000, exp_sout: -32768, exp_settled: 1'b1};
        vecs[9]  = '{ch: 15, tgt: -7,     stp: 5,     exp_sout: -5,     exp_settled: 1'b0};
        vecs[10] = '{ch: 15, tgt: -7,     stp: 5,     exp_sout: -7,     exp_settled: 1'b1};
        vecs[11] = '{ch: 15, tgt: 32767,  stp: 32767, exp_sout: 32760,  exp_settled: 1'b0};
        vecs[12] = '{ch: 15, tgt: 32767,  stp: 32767, exp_sout: 32767,  exp_settled: 1'b1};
        for (int i = 0; i < 16; i++) tj[i] = i * 4099 - 30000;

        // Reset and idle with all targets at zero at the minimum period.
        rst      = 1'b1;
        bus.hold = 1'b0;
        bus.step = 15'd0;
        bus.div  = 16'd15;
        for (int i = 0; i < 16; i++) bus.target[i] = 16'sd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_settled", int'(bus.settled), 0);
        chk("rst_sout_nonzero", count_nonzero(), 0);

        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy == 1'b0 && n < 100);
        chk("first_busy_latency", n, 16);
        lows = 0;
        repeat (48) begin
            @(negedge clk);
            if (!bus.busy) lows++;
        end
        chk("idle_busy_low_cycles", lows, 0);
        chk("idle_settled", int'(bus.settled), 1);
        chk("idle_sout_nonzero", count_nonzero(), 0);
        $display("idle: busy continuous, settled=%0b", bus.settled);

        // Table of ramp steps at P = 100.
        bus.div = 16'd99;
        wait_busy(1'b0, 40, "enter_div99");
        repeat (3) @(negedge clk);
        prev_rise = 0;
        for (int i = 0; i < 13; i++) begin
            bus.target[vecs[i].ch] = 16'(vecs[i].tgt);
            bus.step               = 15'(vecs[i].stp);
            run_sweep($sformatf("vec%0d_sweep", i), rise);
            chk($sformatf("vec%0d_sout%0d", i, vecs[i].ch), int'(obs[vecs[i].ch]), vecs[i].exp_sout);
            chk($sformatf("vec%0d_settled", i), int'(bus.settled), int'(vecs[i].exp_settled));
            if (i > 0) chk($sformatf("vec%0d_tick_spacing", i), rise - prev_rise, 100);
            prev_rise = rise;
            $display("vec %0d: ch %0d target %0d step %0d -> sout %0d settled %0b",
                     i, vecs[i].ch, vecs[i].tgt, vecs[i].stp, obs[vecs[i].ch], bus.settled);
        end

        // Jump mode with div below the clamp: period must be 16.
        bus.step = 15'd0;
        for (int i = 0; i < 16; i++) bus.target[i] = 16'(tj[i]);
        bus.div = 16'd3;
        n = 0;
        while (obs[0] != 16'(tj[0]) && n < 250) begin
            @(negedge clk);
            n++;
        end
        chk("jump_ch0_reached", int'(obs[0]), tj[0]);
        t1 = cyc;
        tj[0] = 1234;
        bus.target[0] = 16'sd1234;
        n = 0;
        while (obs[0] != 16'sd1234 && n < 40) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        chk("jump_period", t2 - t1, 16);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 16; i++) chk($sformatf("jump_sout%0d", i), int'(obs[i]), tj[i]);
        chk("jump_settled", int'(bus.settled), 1);
        lows = 0;
        repeat (32) begin
            @(negedge clk);
            if (!bus.busy) lows++;
        end
        chk("jump_busy_low_cycles", lows, 0);
        $display("jump: period %0d cycles, settled=%0b", t2 - t1, bus.settled);

        // Hold across a tick drops that sweep entirely.
        bus.div = 16'd99;
        wait_busy(1'b0, 40, "enter_hold");
        bus.hold      = 1'b1;
        bus.target[1] = 16'sd777;
        highs = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.busy) highs++;
        end
        chk("hold_busy_high_cycles", highs, 0);
        chk("hold_sout1_frozen", int'(obs[1]), tj[1]);
        bus.hold = 1'b0;
        run_sweep("hold_release", rise);
        chk("hold_release_sout1", int'(obs[1]), 777);
        $display("hold: dropped tick, then sout1 %0d", obs[1]);

        // Hold raised at channel 8 must not abort the running sweep.
        bus.target[2]  = 16'sd55;
        bus.target[12] = -16'sd4321;
        wait_busy(1'b1, 120, "hold_mid_start");
        repeat (8) @(negedge clk);
        bus.hold = 1'b1;
        wait_busy(1'b0, 20, "hold_mid_end");
        chk("hold_mid_sout2", int'(obs[2]), 55);
        chk("hold_mid_sout12", int'(obs[12]), -4321);
        bus.hold = 1'b0;
        $display("hold mid-sweep: sout2 %0d sout12 %0d", obs[2], obs[12]);

        // Reset at idx 5 of a ramping sweep.
        bus.step = 15'd100;
        for (int i = 0; i < 16; i++) bus.target[i] = 16'sd5000;
        wait_busy(1'b1, 120, "rst_mid_start");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_sout_nonzero", count_nonzero(), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_settled", int'(bus.settled), 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy == 1'b0 && n < 300);
        chk("rst_mid_first_busy", n, 100);
        wait_busy(1'b0, 20, "rst_mid_sweep_end");
        repeat (2) @(negedge clk);
        chk("rst_mid_sout0", int'(obs[0]), 100);
        chk("rst_mid_sout15", int'(obs[15]), 100);
        chk("rst_mid_settled_after", int'(bus.settled), 0);
        $display("reset mid-sweep: restart sout0 %0d sout15 %0d", obs[0], obs[15]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
